// File: rtl/cla64_share_ctrl.sv
// ---------------------------------------------------------------------------
// cla64_share_ctrl
//
// Purpose
//   Lets NREQ requesters share a single registered W-bit carry-lookahead
//   adder that lives outside this block. One add is accepted per cycle under
//   round-robin arbitration. The granted operands are registered towards the
//   adder. A small tag pipe follows every accepted op through the adder's
//   pipeline so that the sum and carry can be returned as a one-cycle strobe
//   to the requester that issued them.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   W        operand / sum width, must match the external adder
//   ADD_LAT  clock edges from add_op* valid to add_sum/add_cout valid
//
// Ports
//   clock      in   1        rising-edge clock, shared with the adder
//   reset_n    in   1        asynchronous active-low reset
//   issue_en   in   1        1 = grants allowed, 0 = no new grants (drain only)
//   req_valid  in   NREQ     per-requester operation request
//   req_ready  out  NREQ     one-hot combinational grant
//   req_op1    in   NREQ*W   requester i operand A in bits [i*W +: W]
//   req_op2    in   NREQ*W   requester i operand B in bits [i*W +: W]
//   add_op1    out  W        registered operand A to the adder
//   add_op2    out  W        registered operand B to the adder
//   add_sum    in   W        adder sum
//   add_cout   in   1        adder carry out
//   rsp_valid  out  NREQ     one-hot, one-cycle result strobe
//   rsp_sum    out  W        registered result sum
//   rsp_cout   out  1        registered result carry
//   inflight   out  4        accepted ops that have not yet responded
//
// Timing at the default ADD_LAT=2
//   edge N    : accept, add_op* and tag stage0 load
//   edge N+2  : tag reaches stage(ADD_LAT), lined up with add_sum/add_cout
//   edge N+3  : rsp_* register the result, rsp_valid high for one cycle
//
// The integrator resets the adder from ~reset_n. Ops in flight when reset
// is asserted are dropped, and no response is produced for them.
// ---------------------------------------------------------------------------
module cla64_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int W       = 64,
    parameter int ADD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_en,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_op1,
    input  logic [NREQ*W-1:0] req_op2,
    output logic [W-1:0]      add_op1,
    output logic [W-1:0]      add_op2,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [3:0]        inflight
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW:0] NREQ_EXT = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0]            rr_ptr;
    logic [IDW-1:0]            rr_next;
    logic [IDW:0]              cand;
    logic                      grant_found;
    logic [IDW-1:0]            grant_id;
    logic                      accept;
    logic [W-1:0]              sel_op1;
    logic [W-1:0]              sel_op2;
    logic [ADD_LAT:0]          stage_valid;
    logic [ADD_LAT:0][IDW-1:0] stage_id;
    logic                      rsp_fire;
    logic [3:0]                inflight_next;

    // Round-robin search. Candidates are visited starting at rr_ptr and wrap
    // modulo NREQ. cand is one bit wider than an id, so rr_ptr+k cannot
    // overflow before the wrap subtraction, even when NREQ is not a power
    // of two.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= NREQ_EXT) begin
                cand = cand - NREQ_EXT;
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    // The grant is withheld while in reset and while issue_en is low. It
    // never looks at the response side, because responses cannot be
    // backpressured.
    always_comb begin
        req_ready = '0;
        if (reset_n && issue_en && grant_found) begin
            req_ready = NREQ'(1) << grant_id;
        end
    end

    assign accept = |(req_valid & req_ready);

    // The pointer moves to the requester just after the one accepted, so
    // the requester that was just served has the lowest priority next.
    always_comb begin
        if (grant_id == LAST_ID) begin
            rr_next = '0;
        end else begin
            rr_next = grant_id + 1'b1;
        end
    end

    // Operand mux for the granted requester. Operands are only used at the
    // accept edge, so a requester may change them while it waits.
    always_comb begin
        sel_op1 = req_op1[int'(grant_id)*W +: W];
        sel_op2 = req_op2[int'(grant_id)*W +: W];
    end

    // Arbitration pointer. It only moves on an accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_next;
        end
    end

    // Operand registers towards the adder. They hold between accepts so
    // the adder inputs do not toggle while the block is idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            add_op1 <= '0;
            add_op2 <= '0;
        end else if (accept) begin
            add_op1 <= sel_op1;
            add_op2 <= sel_op2;
        end
    end

    // Tag pipe. Stage 0 loads with the operands. Stage ADD_LAT is therefore
    // valid in the same cycle that the adder presents the matching sum.
    // Idle slots carry a don't-care id, and only the valid bit matters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid <= '0;
            stage_id    <= '0;
        end else begin
            stage_valid <= {stage_valid[ADD_LAT-1:0], accept};
            stage_id    <= {stage_id[ADD_LAT-1:0], grant_id};
        end
    end

    assign rsp_fire = stage_valid[ADD_LAT];

    // Response register. The sum and carry keep their last value between
    // strobes. Because the tag pipe is a plain shift register, results
    // leave in the same order in which they were accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            if (rsp_fire) begin
                rsp_valid <= NREQ'(1) << stage_id[ADD_LAT];
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

    // In-flight counter. An accept and a response on the same edge cancel
    // out. This keeps the count at ADD_LAT+1 during back-to-back issue.
    always_comb begin
        inflight_next = inflight;
        case ({accept, rsp_fire})
            2'b10:   inflight_next = inflight + 4'd1;
            2'b01:   inflight_next = inflight - 4'd1;
            default: inflight_next = inflight;
        endcase
    end

    // Registered copy of the in-flight count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            inflight <= inflight_next;
        end
    end

endmodule

// File: tb/tb_cla64_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cla64_share_ctrl
//
// Drives cla64_share_ctrl with directed scenarios and then random traffic.
// A registered two-stage adder stands in for the external CLA. The
// reference model keeps a queue of expected responses. Each entry holds the
// id, the 65-bit arithmetic total and the edge on which its strobe is due.
// Grants are chosen by a plain round-robin search over an integer pointer.
// ---------------------------------------------------------------------------
module tb_cla64_share_ctrl;

    localparam int NREQ    = 4;
    localparam int W       = 64;
    localparam int ADD_LAT = 2;

    logic              clock;
    logic              reset_n;
    logic              issue_en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_op1;
    logic [NREQ*W-1:0] req_op2;
    logic [W-1:0]      add_op1;
    logic [W-1:0]      add_op2;
    logic [W-1:0]      add_sum;
    logic              add_cout;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [3:0]        inflight;

    typedef struct {
        int         id;
        logic [W:0] total;
        int         due;
    } expRsp_t;

    expRsp_t    pending[$];
    int         rrModel;
    int         edgeCount;
    logic [W-1:0] expOp1;
    logic [W-1:0] expOp2;
    logic [W-1:0] lastSum;
    logic       lastCout;
    int         checks;
    int         errors;

    logic [W:0] adderS1;
    logic [W:0] adderS2;

    cla64_share_ctrl #(.NREQ(NREQ), .W(W), .ADD_LAT(ADD_LAT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .issue_en  (issue_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .add_op1   (add_op1),
        .add_op2   (add_op2),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .inflight  (inflight)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the external registered adder: two edges of latency,
    // reset from ~reset_n as the integrator would wire it.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            adderS1 <= '0;
            adderS2 <= '0;
        end else begin
            adderS1 <= {1'b0, add_op1} + {1'b0, add_op2};
            adderS2 <= adderS1;
        end
    end

    assign add_sum  = adderS2[W-1:0];
    assign add_cout = adderS2[W];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic enable);
        req_valid = valid;
        issue_en  = enable;
    endtask

    task automatic setOps(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op1[i*W +: W] = a;
        req_op2[i*W +: W] = b;
    endtask

    function automatic int modelGrant();
        int idx;
        if (!reset_n || !issue_en) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (rrModel + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle. It is entered at a negedge with the inputs already
    // applied, and it returns at the next negedge.
    task automatic runCycle();
        int g;
        logic [NREQ-1:0] expReady;
        logic [NREQ-1:0] expValid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        expRsp_t e;
        #1;
        g = modelGrant();
        expReady = (g >= 0) ? (NREQ'(1) << g) : '0;
        checkOutput("req_ready", 64'(req_ready), 64'(expReady));
        @(posedge clock);
        edgeCount++;
        if (g >= 0) begin
            a = req_op1[g*W +: W];
            b = req_op2[g*W +: W];
            pending.push_back('{g, {1'b0, a} + {1'b0, b}, edgeCount + ADD_LAT + 1});
            expOp1  = a;
            expOp2  = b;
            rrModel = (g + 1) % NREQ;
        end
        #1;
        expValid = '0;
        if (pending.size() > 0 && pending[0].due == edgeCount) begin
            e        = pending.pop_front();
            expValid = NREQ'(1) << e.id;
            lastSum  = e.total[W-1:0];
            lastCout = e.total[W];
        end
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(expValid));
        checkOutput("rsp_sum", rsp_sum, lastSum);
        checkOutput("rsp_cout", 64'(rsp_cout), 64'(lastCout));
        checkOutput("inflight", 64'(inflight), 64'(pending.size()));
        checkOutput("add_op1", add_op1, expOp1);
        checkOutput("add_op2", add_op2, expOp2);
        @(negedge clock);
    endtask

    task automatic doReset(input int cycles);
        reset_n = 1'b0;
        pending.delete();
        rrModel  = 0;
        lastSum  = '0;
        lastCout = 1'b0;
        expOp1   = '0;
        expOp2   = '0;
        #1;
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_sum", rsp_sum, 64'd0);
        checkOutput("rst_rsp_cout", 64'(rsp_cout), 64'd0);
        checkOutput("rst_inflight", 64'(inflight), 64'd0);
        checkOutput("rst_add_op1", add_op1, 64'd0);
        repeat (cycles) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        checks    = 0;
        errors    = 0;
        edgeCount = 0;
        rrModel   = 0;
        reset_n   = 1'b0;
        req_op1   = '0;
        req_op2   = '0;
        applyStimulus('0, 1'b1);
        @(negedge clock);
        doReset(2);

        $display("[TB] carry out of all-ones plus one");
        setOps(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        applyStimulus(4'b0001, 1'b1);
        runCycle();
        applyStimulus(4'b0000, 1'b1);
        repeat (4) runCycle();

        $display("[TB] back-to-back ids 2 and 3");
        setOps(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        setOps(3, 64'd5, 64'd7);
        applyStimulus(4'b0100, 1'b1);
        runCycle();
        applyStimulus(4'b1000, 1'b1);
        runCycle();
        applyStimulus(4'b0000, 1'b1);
        repeat (4) runCycle();

        $display("[TB] reset with ops in flight");
        setOps(1, 64'd100, 64'd200);
        setOps(2, 64'd300, 64'd400);
        applyStimulus(4'b0110, 1'b1);
        repeat (2) runCycle();
        doReset(1);
        applyStimulus(4'b0000, 1'b1);
        repeat (4) runCycle();

        $display("[TB] all requesters continuously");
        for (int i = 0; i < NREQ; i++) setOps(i, 64'(i * 1000 + 1), 64'(i + 7));
        applyStimulus(4'b1111, 1'b1);
        repeat (8) runCycle();
        applyStimulus(4'b0000, 1'b1);
        repeat (4) runCycle();

        $display("[TB] issue disabled then enabled");
        setOps(1, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF);
        applyStimulus(4'b0010, 1'b0);
        repeat (5) runCycle();
        applyStimulus(4'b0010, 1'b1);
        runCycle();
        applyStimulus(4'b0000, 1'b1);
        repeat (4) runCycle();

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if ($urandom_range(0, 9) == 0) ra = '1;
                if ($urandom_range(0, 9) == 0) rb = 64'h8000_0000_0000_0000;
                setOps(i, ra, rb);
            end
            applyStimulus(NREQ'($urandom), $urandom_range(0, 7) != 0);
            if (c == 200) begin
                doReset(1);
            end else begin
                runCycle();
            end
        end
        applyStimulus(4'b0000, 1'b1);
        repeat (5) runCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
